// File: rtl/fpadd_pkg.sv
// Shared types and constants for the fpadd issue controller.
package fpadd_pkg;
  localparam int FP_W = 32;
  localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC00000;
  localparam int DEF_TIMEOUT = 63;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_HOLD
  } state_t;
endpackage

// File: rtl/fpadd_opq.sv
// Operand-pair queue: DEPTH-entry synchronous FIFO, head visible combinationally.
// Callers must not push when full or pop when empty.
module fpadd_opq #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           push_data,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; count and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/fpadd_issue.sv
// Issue controller for the multi-cycle fpadd: queues operand pairs, starts the adder,
// waits for done (with watchdog) and holds each result until the consumer takes it.
module fpadd_issue
  import fpadd_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [FP_W-1:0] in_a,
  input  logic [FP_W-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [FP_W-1:0] out_sum,
  output logic            out_err,
  output logic            add_start,
  output logic [FP_W-1:0] add_a,
  output logic [FP_W-1:0] add_b,
  input  logic            add_done,
  input  logic [FP_W-1:0] add_sum,
  output logic            busy
);
  localparam logic [7:0] TO8 = 8'(TIMEOUT);

  state_t                  state;
  state_t                  state_nxt;
  logic [7:0]              wait_cnt;
  logic                    push;
  logic                    pop;
  logic                    load;
  logic                    cap_done;
  logic                    cap_to;
  logic                    accept;
  logic [2*FP_W-1:0]       head;
  logic [2*FP_W-1:0]       load_data;
  logic [$clog2(DEPTH):0]  count;
  logic                    full;
  logic                    empty;

  fpadd_opq #(.DEPTH(DEPTH), .W(2*FP_W)) u_opq (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data ({in_a, in_b}),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign in_ready  = !full;
  assign push      = in_valid && in_ready;
  assign add_start = (state == ST_ISSUE);
  assign busy      = (state != ST_IDLE) || (count != '0);
  // A pair pushed during the accepting HOLD cycle is not at the head yet.
  assign load_data = empty ? {in_a, in_b} : head;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load      = 1'b0;
    cap_done  = 1'b0;
    cap_to    = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          load      = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        // First WAIT cycle is blanked: done may still be left over from the previous op.
        if (add_done && (wait_cnt != 8'd0)) begin
          cap_done  = 1'b1;
          pop       = 1'b1;
          state_nxt = ST_HOLD;
        end else if (wait_cnt == TO8) begin
          cap_to    = 1'b1;
          pop       = 1'b1;
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          accept = 1'b1;
          if (!empty || push) begin
            load      = 1'b1;
            state_nxt = ST_ISSUE;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      wait_cnt  <= 8'd0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_err   <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_ISSUE)
        wait_cnt <= 8'd0;
      else if ((state == ST_WAIT) && (wait_cnt != TO8))
        wait_cnt <= wait_cnt + 8'd1;
      if (load)
        {add_a, add_b} <= load_data;
      if (cap_done) begin
        out_sum   <= add_sum;
        out_err   <= 1'b0;
        out_valid <= 1'b1;
      end else if (cap_to) begin
        out_sum   <= FP_QNAN;
        out_err   <= 1'b1;
        out_valid <= 1'b1;
      end else if (accept) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fpadd_issue.sv
// Bench for fpadd_issue: adder model with configurable latency, vector table,
// corner sequences, a timeout instance and a randomized scoreboard run.
module tb_fpadd_issue;
  localparam int TO_B = 8;
  localparam int NR   = 60;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: default watchdog, driven by the adder model.
  logic        in_valid, in_ready, out_valid, out_ready, out_err, add_start, add_done, busy;
  logic [31:0] in_a, in_b, out_sum, add_a, add_b, add_sum;

  fpadd_issue #(.DEPTH(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_err(out_err), .add_start(add_start), .add_a(add_a),
    .add_b(add_b), .add_done(add_done), .add_sum(add_sum), .busy(busy)
  );

  // Instance B: short watchdog, adder that never finishes.
  logic        in_valid_t, in_ready_t, out_valid_t, out_ready_t, out_err_t, add_start_t, busy_t;
  logic [31:0] in_a_t, in_b_t, out_sum_t, add_a_t, add_b_t;

  fpadd_issue #(.DEPTH(2), .TIMEOUT(TO_B)) dut_to (
    .clk(clk), .reset(reset), .in_valid(in_valid_t), .in_ready(in_ready_t),
    .in_a(in_a_t), .in_b(in_b_t), .out_valid(out_valid_t), .out_ready(out_ready_t),
    .out_sum(out_sum_t), .out_err(out_err_t), .add_start(add_start_t), .add_a(add_a_t),
    .add_b(add_b_t), .add_done(1'b0), .add_sum(32'h0), .busy(busy_t)
  );

  // Single-precision add through double arithmetic (normal operands only).
  function automatic logic [63:0] to_dbl(input logic [31:0] x);
    return {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'b0};
  endfunction
  function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
    real r;
    logic [63:0] d;
    r = $bitstoreal(to_dbl(a)) + $bitstoreal(to_dbl(b));
    d = $realtobits(r);
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction
  function automatic logic [31:0] rand_op();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)};
  endfunction

  // Adder model: done rises k_cfg cycles after start; in stale mode it clears one cycle late.
  int          k_cfg = 5;
  bit          stale_mode = 1'b0;
  logic        done_m = 1'b0;
  logic [31:0] sum_m = '0;
  logic [31:0] sum_pend = '0;
  int          kcnt = 0;
  bit          stale_clr = 1'b0;
  always @(posedge clk) begin
    if (add_start) begin
      sum_pend <= model_add(add_a, add_b);
      kcnt     <= k_cfg;
      if (!stale_mode) done_m <= 1'b0;
      stale_clr <= stale_mode;
    end else begin
      if (stale_clr) begin
        done_m    <= 1'b0;
        stale_clr <= 1'b0;
      end
      if (kcnt > 1) kcnt <= kcnt - 1;
      else if (kcnt == 1) begin
        done_m <= 1'b1;
        sum_m  <= sum_pend;
        kcnt   <= 0;
      end
    end
  end
  assign add_done = done_m;
  assign add_sum  = sum_m;

  int checks = 0;
  int errors = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input string name, output int c);
    int t = 0;
    while (!add_start && t < 300) begin step(); t++; end
    check({name, " start seen"}, 64'(add_start), 64'd1);
    c = cyc;
  endtask

  task automatic wait_valid(input string name, output int c, output int ns);
    int t = 0;
    ns = 0;
    while (!out_valid && t < 300) begin
      if (add_start) ns++;
      step();
      t++;
    end
    check({name, " valid seen"}, 64'(out_valid), 64'd1);
    c = cyc;
  endtask

  task automatic push_one(input logic [31:0] a, input logic [31:0] b);
    in_a = a; in_b = b; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic accept();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          k;
    logic [31:0] sum;
  } vec_t;
  vec_t vec[5];

  initial begin
    int c0, cs, cv, ns, t, bad, starts;
    logic [31:0] qa[3], qb[3], hs;
    logic        he;
    logic [63:0] pq[$];
    int          pushed, iss_idx, out_idx;

    vec[0] = '{32'h3F800000, 32'h40000000, 10, 32'h40400000};
    vec[1] = '{32'h40000000, 32'h40000000, 1,  32'h40800000};
    vec[2] = '{32'h3FC00000, 32'h3F000000, 4,  32'h40000000};
    vec[3] = '{32'h3F000000, 32'h3E800000, 12, 32'h3F400000};
    vec[4] = '{32'h41200000, 32'hC0800000, 7,  32'h40C00000};

    in_valid = 0; in_a = 0; in_b = 0; out_ready = 0;
    in_valid_t = 0; in_a_t = 0; in_b_t = 0; out_ready_t = 0;

    reset = 1'b1;
    step(); step();
    check("rst in_ready", 64'(in_ready), 64'd1);
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst out_sum", 64'(out_sum), 64'd0);
    check("rst out_err", 64'(out_err), 64'd0);
    check("rst add_start", 64'(add_start), 64'd0);
    check("rst add_ab", {add_a, add_b}, 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    reset = 1'b0;
    step();

    // Table of single ops from an empty, idle controller.
    for (int i = 0; i < 5; i++) begin
      k_cfg = vec[i].k;
      c0 = cyc;
      push_one(vec[i].a, vec[i].b);
      wait_start("vec", cs);
      check("vec start latency", 64'(cs - c0), 64'd2);
      check("vec add_ab", {add_a, add_b}, {vec[i].a, vec[i].b});
      step();
      wait_valid("vec", cv, ns);
      check("vec result latency", 64'(cv - cs), 64'(vec[i].k + 2));
      check("vec extra starts", 64'(ns), 64'd0);
      check("vec sum", 64'(out_sum), 64'(vec[i].sum));
      check("vec err", 64'(out_err), 64'd0);
      accept();
      check("vec valid drop", 64'(out_valid), 64'd0);
      check("vec busy drop", 64'(busy), 64'd0);
    end

    // Stale done from the previous op must be blanked.
    stale_mode = 1'b1;
    k_cfg = 5;
    push_one(32'h40400000, 32'h3F800000);
    wait_start("stale", cs);
    step();
    wait_valid("stale", cv, ns);
    check("stale latency", 64'(cv - cs), 64'd7);
    check("stale sum", 64'(out_sum), 64'h40800000);
    accept();
    stale_mode = 1'b0;

    // Fill the queue with out_ready low; third pair must see in_ready low.
    k_cfg = 3;
    for (int i = 0; i < 3; i++) begin qa[i] = rand_op(); qb[i] = rand_op(); end
    for (int i = 0; i < 3; i++) begin
      in_a = qa[i]; in_b = qb[i]; in_valid = 1'b1;
      if (i == 2) check("full in_ready", 64'(in_ready), 64'd0);
      t = 0;
      while (!in_ready && t < 100) begin step(); t++; end
      if (i == 2) check("full drains", 64'(in_ready), 64'd1);
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_valid("full", cv, ns);
      check("full order sum", 64'(out_sum), 64'(model_add(qa[i], qb[i])));
      check("full err", 64'(out_err), 64'd0);
      accept();
    end
    check("full busy", 64'(busy), 64'd0);

    // Long backpressure in HOLD with a second op queued.
    k_cfg = 2;
    qa[0] = rand_op(); qb[0] = rand_op(); qa[1] = rand_op(); qb[1] = rand_op();
    push_one(qa[0], qb[0]);
    push_one(qa[1], qb[1]);
    wait_valid("bp", cv, ns);
    hs = out_sum; he = out_err; bad = 0; starts = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_sum !== hs || out_err !== he || out_valid !== 1'b1) bad++;
      if (add_start) starts++;
    end
    check("bp sum", 64'(hs), 64'(model_add(qa[0], qb[0])));
    check("bp unstable cycles", 64'(bad), 64'd0);
    check("bp early starts", 64'(starts), 64'd0);
    accept();
    check("bp issue after accept", 64'(add_start), 64'd1);
    check("bp next operands", {add_a, add_b}, {qa[1], qb[1]});
    wait_valid("bp2", cv, ns);
    check("bp2 sum", 64'(out_sum), 64'(model_add(qa[1], qb[1])));
    accept();

    // Reset while the adder is busy.
    k_cfg = 30;
    push_one(32'h3F800000, 32'h3F800000);
    wait_start("rstw", cs);
    step(); step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rstw out_valid", 64'(out_valid), 64'd0);
    check("rstw out_sum", 64'(out_sum), 64'd0);
    check("rstw add_ab", {add_a, add_b}, 64'd0);
    check("rstw add_start", 64'(add_start), 64'd0);
    check("rstw busy", 64'(busy), 64'd0);
    check("rstw in_ready", 64'(in_ready), 64'd1);
    k_cfg = 4;
    c0 = cyc;
    push_one(32'h40000000, 32'h3F800000);
    wait_start("rstw2", cs);
    check("rstw2 start latency", 64'(cs - c0), 64'd2);
    step();
    wait_valid("rstw2", cv, ns);
    check("rstw2 sum", 64'(out_sum), 64'h40400000);
    accept();

    // Watchdog instance: two ops that both time out.
    qa[0] = rand_op(); qb[0] = rand_op(); qa[1] = rand_op(); qb[1] = rand_op();
    for (int i = 0; i < 2; i++) begin
      in_a_t = qa[i]; in_b_t = qb[i]; in_valid_t = 1'b1;
      step();
    end
    in_valid_t = 1'b0;
    t = 0;
    while (!add_start_t && t < 50) begin step(); t++; end
    check("to start seen", 64'(add_start_t), 64'd1);
    cs = cyc;
    for (int i = 0; i < 2; i++) begin
      t = 0;
      step();
      while (!out_valid_t && t < 100) begin step(); t++; end
      check("to latency", 64'(cyc - cs), 64'(TO_B + 2));
      check("to sum", 64'(out_sum_t), 64'h7FC00000);
      check("to err", 64'(out_err_t), 64'd1);
      out_ready_t = 1'b1;
      step();
      out_ready_t = 1'b0;
      if (i == 0) begin
        check("to next issues", 64'(add_start_t), 64'd1);
        check("to next operands", {add_a_t, add_b_t}, {qa[1], qb[1]});
        cs = cyc;
      end
    end
    check("to busy", 64'(busy_t), 64'd0);

    // Randomized traffic against an in-order scoreboard.
    pushed = 0; iss_idx = 0; out_idx = 0;
    for (int i = 0; i < 6000 && out_idx < NR; i++) begin
      if (add_start) begin
        if (iss_idx < pq.size()) check("rnd issue operands", {add_a, add_b}, pq[iss_idx]);
        else check("rnd issue without push", 64'(iss_idx), 64'(pq.size()));
        iss_idx++;
      end
      if (out_valid && out_ready) begin
        check("rnd sum", 64'(out_sum), 64'(model_add(pq[out_idx][63:32], pq[out_idx][31:0])));
        check("rnd err", 64'(out_err), 64'd0);
        out_idx++;
      end
      if (in_valid && in_ready) begin
        pq.push_back({in_a, in_b});
        pushed++;
      end
      step();
      in_valid  = (pushed < NR) && ($urandom_range(0, 2) != 0);
      in_a      = rand_op();
      in_b      = rand_op();
      out_ready = ($urandom_range(0, 3) != 0);
      k_cfg     = $urandom_range(1, 15);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("rnd all results", 64'(out_idx), 64'(NR));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/fpadd_issue.md
# fpadd_issue

Upstream issue controller for the multi-cycle single-precision adder `fpadd`. It accepts operand pairs on a valid/ready stream and buffers them in a small queue. It sequences each pair into the adder with a one-cycle `start` pulse, waits for `done`, and returns the sum on a valid/ready result stream. A watchdog catches an adder that never finishes.

## Interface
Parameters:
- DEPTH, 2: operand queue entries; power of 2, ≥2.
- TIMEOUT, 63: maximum WAIT cycles before abort; 8 ≤ TIMEOUT ≤ 255.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  queue not full.
- in_a, in_b  in  32  IEEE-754 single operands.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_sum  out  32  sum, or 32'h7FC00000 on timeout.
- out_err  out  1  result produced by timeout.
- add_start  out  1  start pulse to the adder.
- add_a, add_b  out  32  operands to the adder, registered.
- add_done  in  1  adder done; level, cleared by the adder on start.
- add_sum  in  32  adder result, valid while add_done=1.
- busy  out  1  state ≠ IDLE or queue non-empty.

## Operation
- Queue: push on in_valid&&in_ready. in_ready = (count≠DEPTH), taken from registered count only; no same-cycle pop-through when full. Pointers wrap modulo DEPTH.
- FSM states are IDLE, ISSUE, WAIT, HOLD.
  - IDLE: if count≠0, load add_a/add_b from queue head, then → ISSUE.
  - ISSUE: add_start=1 for exactly this cycle; clear wait counter; → WAIT.
  - WAIT: wait counter increments every cycle. add_done is ignored while counter=0 (blanking for the adder's clear latency).
    - On add_done=1 with counter≥1: capture add_sum into out_sum, set out_err=0, out_valid=1, pop queue, → HOLD.
    - Else, when counter=TIMEOUT: out_sum=32'h7FC00000, out_err=1, out_valid=1, pop, → HOLD.
    - done takes priority if both occur in the same cycle.
  - HOLD: out_valid, out_sum and out_err are held stable until out_ready=1. On the accepting edge out_valid←0. Then, if count≠0 (count evaluated after this cycle's push), load the next operands and → ISSUE; else → IDLE.
- add_a/add_b change only on a transition into ISSUE and stay stable through WAIT and HOLD.
- The block does no arithmetic on operands; the wait counter is 8 bits and saturates at TIMEOUT.

## Timing
- Reset values: in_ready=1, out_valid=0, out_sum=0, out_err=0, add_start=0, add_a=0, add_b=0, busy=0; state=IDLE; queue empty.
- Empty-idle latency: pair accepted at edge N; ISSUE (add_start=1) in cycle N+2; done is first sampled in cycle N+4.
- Result: out_valid rises the cycle after the qualifying add_done. Per-op overhead is 3 cycles plus the adder latency. Back-to-back ops skip IDLE.
- Reset mid-operation: state, queue and outputs return to reset values next cycle. The adder is not reset by this block; the next add_start restarts it.
- Push while in HOLD or WAIT is allowed while not full.
- out_ready while out_valid=0 has no effect.

## Structure
- Package `fpadd_pkg` contains:
  - state enum;
  - `FP_W=32`;
  - `FP_QNAN=32'h7FC00000`;
  - default `TIMEOUT`.
- One sub-module, `fpadd_opq`: a DEPTH-entry 64-bit synchronous FIFO with push/pop/count/full/empty and head data. It is instantiated once.
- The FSM, watchdog and result register live in `fpadd_issue`.

## Test plan
The bench uses an adder model that raises done K cycles after start and drops it on start.
- Single op, K=10: push a=3F800000, b=40000000 with model sum 40400000. Required: one add_start pulse in cycle N+2; out_valid with out_sum=40400000, out_err=0; busy falls after out_ready.
- Stale done: the model holds add_done=1 from the previous op through the blanking cycle. Required: no premature result; the capture waits for the new done.
- Queue full, DEPTH=2, out_ready=0: push 3 pairs back-to-back. Required: the third cycle sees in_ready=0. After three out_ready handshakes, the three sums appear in push order.
- Timeout, TIMEOUT=8, model never asserts done. Required: out_sum=7FC00000, out_err=1 exactly 8 WAIT cycles after start; the next queued op then issues.
- Backpressure: hold out_ready=0 for 20 cycles in HOLD. Required: out_sum/out_err stable; no add_start until acceptance.
- Reset asserted in WAIT. Required: all outputs at reset values next cycle; queue empty; a fresh push then completes normally.
